// File: rtl/phase_stim_pkg.sv
// Shared definitions for the phase stimulus clock generator.
//   DEF_PHASE_W  : default phase/accumulator width (1 LSB = 2^-W cycle)
//   phase_t      : signed phase word at the default width
//   cyc_to_phase : converts a fraction of a cycle into phase LSBs,
//                  truncating toward zero (elaboration-time helper)
package phase_stim_pkg;

  localparam int DEF_PHASE_W = 16;

  typedef logic signed [DEF_PHASE_W-1:0] phase_t;

  function automatic int cyc_to_phase(real cyc);
    return $rtoi(cyc * real'(longint'(1) << DEF_PHASE_W));
  endfunction

endpackage

// File: rtl/phase_stim_clkgen_if.sv
// Output bundle of the phase stimulus generator.
//   en      : run enable (driven by master)
//   rphase  : reference phase, signed fraction of a cycle
//   fbphase : piecewise-linear feedback phase
//   rclk    : reference clock
//   fbclk   : feedback clock
//   tcnt    : elapsed enabled cycles
interface phase_stim_clkgen_if
  import phase_stim_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int TCNT_W  = 32
);

  logic                      en;
  logic signed [PHASE_W-1:0] rphase;
  logic signed [PHASE_W-1:0] fbphase;
  logic                      rclk;
  logic                      fbclk;
  logic [TCNT_W-1:0]         tcnt;

  modport master (output en, input rphase, fbphase, rclk, fbclk, tcnt);
  modport slave  (input en, output rphase, fbphase, rclk, fbclk, tcnt);

endinterface

// File: rtl/nco_clk_slice.sv
// One NCO output slice: adds a phase offset to the shared accumulator and
// registers the top bit of the sum as a 50%-duty clock.
//   clk, rst_n : clock, synchronous active-low reset
//   en_i       : hold the output clock when low
//   acc_i      : shared NCO accumulator (pre-update value)
//   phase_i    : signed phase offset, fraction of a cycle
//   clk_o      : registered clock output
module nco_clk_slice
  import phase_stim_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic [PHASE_W-1:0]        acc_i,
  input  logic signed [PHASE_W-1:0] phase_i,
  output logic                      clk_o
);

  localparam logic [PHASE_W-1:0] HALF = {1'b1, {(PHASE_W-1){1'b0}}};

  // Sum wraps modulo one cycle, so any phase offset is legal.
  logic [PHASE_W-1:0] sum;
  logic               clk_q;

  assign sum = acc_i + phase_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_q <= 1'b0;
    end else if (en_i) begin
      // Upper half of the cycle is the high phase of the clock.
      clk_q <= (sum >= HALF);
    end
  end

  assign clk_o = clk_q;

endmodule

// File: rtl/phase_stim_clkgen.sv
// Stimulus generator for TDC/PLL benches. Produces a constant reference
// phase and a piecewise-linear feedback phase, each turned into a clock by
// an NCO slice sharing one accumulator.
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of phase_stim_clkgen_if (en in; rphase, fbphase,
//           rclk, fbclk, tcnt out)
module phase_stim_clkgen
  import phase_stim_pkg::*;
#(
  parameter int PHASE_W  = DEF_PHASE_W,
  parameter int FCW      = 4096,
  parameter int DC_PHASE = 0,
  parameter int T0       = 100,
  parameter int V0       = -13107,
  parameter int T1       = 1300,
  parameter int V1       = 13107,
  parameter int TCNT_W   = 32
) (
  input logic                clk,
  input logic                rst_n,
  phase_stim_clkgen_if.slave bus
);

  // Ramp constants: whole step Q per cycle plus a Bresenham-style
  // remainder R accumulated against DT, so no runtime divider is needed.
  localparam longint DV  = longint'(V1) - longint'(V0);
  localparam longint DT  = longint'(T1) - longint'(T0);
  localparam longint Q   = DV / DT;
  localparam longint R   = ((DV < 0) ? -DV : DV) % DT;
  localparam longint S   = (DV > 0) ? 1 : ((DV < 0) ? -1 : 0);
  localparam longint LIM = longint'(1) << PHASE_W;

  localparam logic signed [PHASE_W:0]   Q_X   = (PHASE_W+1)'(Q);
  localparam logic signed [PHASE_W:0]   S_X   = (PHASE_W+1)'(S);
  localparam logic signed [PHASE_W-1:0] V0_P  = PHASE_W'(V0);
  localparam logic signed [PHASE_W-1:0] DC_P  = PHASE_W'(DC_PHASE);
  localparam logic [PHASE_W-1:0]        FCW_P = PHASE_W'(FCW);
  localparam logic [TCNT_W-1:0]         T0_T  = TCNT_W'(T0);
  localparam logic [TCNT_W-1:0]         T1_T  = TCNT_W'(T1);
  localparam logic [TCNT_W:0]           R_X   = (TCNT_W+1)'(R);
  localparam logic [TCNT_W:0]           DT_X  = (TCNT_W+1)'(DT);

  if (T1 <= T0) begin : g_bad_t
    $error("phase_stim_clkgen: T1 must exceed T0");
  end
  if (DV < -LIM || DV >= LIM) begin : g_bad_dv
    $error("phase_stim_clkgen: V1-V0 does not fit in PHASE_W+1 bits");
  end
  if (longint'(T1) >= (longint'(1) << TCNT_W)) begin : g_bad_t1
    $error("phase_stim_clkgen: T1 does not fit in TCNT_W bits");
  end
  if (FCW < 1 || longint'(FCW) > (LIM >> 1)) begin : g_bad_fcw
    $error("phase_stim_clkgen: FCW out of range");
  end

  logic [TCNT_W-1:0]         tcnt_q, tcnt_d;
  logic signed [PHASE_W-1:0] fbphase_q, fbphase_d;
  logic signed [PHASE_W-1:0] rphase_q;
  logic [TCNT_W:0]           err_q, err_d, err_sum;
  logic signed [PHASE_W:0]   fb_ext;
  logic [PHASE_W-1:0]        acc_q;
  logic                      in_ramp;
  logic                      rclk, fbclk;

  always_comb begin
    // Saturate instead of wrapping so the ramp never restarts.
    tcnt_d    = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
    in_ramp   = (tcnt_q >= T0_T) && (tcnt_q < T1_T);
    err_sum   = err_q + R_X;
    fb_ext    = (PHASE_W+1)'(fbphase_q) + Q_X;
    err_d     = err_q;
    fbphase_d = fbphase_q;
    if (in_ramp) begin
      if (err_sum >= DT_X) begin
        err_d  = err_sum - DT_X;
        fb_ext = fb_ext + S_X;
      end else begin
        err_d  = err_sum;
      end
      fbphase_d = PHASE_W'(fb_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt_q    <= '0;
      fbphase_q <= V0_P;
      rphase_q  <= DC_P;
      err_q     <= '0;
      acc_q     <= '0;
    end else begin
      rphase_q <= DC_P;
      if (bus.en) begin
        tcnt_q    <= tcnt_d;
        fbphase_q <= fbphase_d;
        err_q     <= err_d;
        acc_q     <= acc_q + FCW_P;
      end
    end
  end

  // Both slices see the pre-update accumulator and current phase registers.
  nco_clk_slice #(.PHASE_W(PHASE_W)) u_rclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (bus.en),
    .acc_i  (acc_q),
    .phase_i(rphase_q),
    .clk_o  (rclk)
  );

  nco_clk_slice #(.PHASE_W(PHASE_W)) u_fbclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (bus.en),
    .acc_i  (acc_q),
    .phase_i(fbphase_q),
    .clk_o  (fbclk)
  );

  assign bus.rphase  = rphase_q;
  assign bus.fbphase = fbphase_q;
  assign bus.rclk    = rclk;
  assign bus.fbclk   = fbclk;
  assign bus.tcnt    = tcnt_q;

endmodule

// File: tb/tb_phase_stim_clkgen.sv
module tb_phase_stim_clkgen;
  import phase_stim_pkg::*;

  localparam int T0  = 100;
  localparam int T1  = 1300;
  localparam int V0  = -13107;
  localparam int V1  = 13107;
  localparam int FCW = 4096;
  localparam int DC  = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  phase_stim_clkgen_if bus ();

  phase_stim_clkgen dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint tcnt;
    phase_t fb;
    phase_t rph;
    logic   rclk;
    logic   fbclk;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  longint m_tcnt;
  int     m_acc;
  longint m_fb;
  logic   m_rclk, m_fbclk;

  // trackers
  int     phase_sel = 0;
  int     rel_edges, run_len, ecyc, last_rr;
  bit     first_seen, rr_valid;
  logic   prev_rclk, prev_fbclk;
  longint prev_fb;
  longint fb_hist [0:800];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint f_ref(input longint t);
    if (t <= T0) return V0;
    if (t >= T1) return V1;
    return V0 + ((longint'(V1) - V0) * (t - T0)) / (T1 - T0);
  endfunction

  task automatic tick(input logic r, input logic e);
    exp_t x;
    exp_t y;
    longint d;
    int lag;
    rst_n  = r;
    bus.en = e;
    if (!r) begin
      m_tcnt = 0; m_acc = 0; m_fb = V0; m_rclk = 1'b0; m_fbclk = 1'b0;
    end else if (e) begin
      m_rclk  = ((m_acc + DC) & 65535) >= 32768;
      m_fbclk = ((m_acc + int'(m_fb)) & 65535) >= 32768;
      m_acc   = (m_acc + FCW) & 65535;
      if (m_tcnt < 64'hFFFF_FFFF) m_tcnt++;
      m_fb    = f_ref(m_tcnt);
    end
    x.tcnt = m_tcnt; x.fb = phase_t'(m_fb); x.rph = phase_t'(DC);
    x.rclk = m_rclk; x.fbclk = m_fbclk;
    sb.push_back(x);

    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk("tcnt",    bus.tcnt,    y.tcnt);
    chk("fbphase", bus.fbphase, y.fb);
    chk("rphase",  bus.rphase,  y.rph);
    chk("rclk",    bus.rclk,    y.rclk);
    chk("fbclk",   bus.fbclk,   y.fbclk);

    if (!r) begin
      run_len = 0; rel_edges = 0; ecyc = 0; last_rr = 0;
      first_seen = 1'b0; rr_valid = 1'b0;
      prev_rclk = 1'b0; prev_fbclk = 1'b0;
    end else if (e) begin
      ecyc++;
      rel_edges++;
      if (bus.rclk && !first_seen) begin
        first_seen = 1'b1;
        chk("rclk_first_edge", rel_edges, 9);
      end
      if (bus.rclk != prev_rclk) begin
        chk("rclk_run_len", run_len, 8);
        run_len = 1;
      end else begin
        run_len++;
      end
      if (bus.rclk && !prev_rclk) begin
        last_rr  = ecyc;
        rr_valid = 1'b1;
      end
      if (bus.fbclk && !prev_fbclk && rr_valid) begin
        lag = ecyc - last_rr;
        if (bus.tcnt <= T0)        chk("fb_lag_early", lag, 4);
        else if (bus.tcnt >= 1320) chk("fb_lag_late", lag, 13);
      end
      if (bus.tcnt > T0 && bus.tcnt <= T1) begin
        d = longint'(bus.fbphase) - prev_fb;
        chk("ramp_step_21_22", longint'(d == 21 || d == 22), 1);
      end
      if (bus.tcnt <= T0)  chk("fb_hold_v0", bus.fbphase, V0);
      if (bus.tcnt == 101) chk("fb_t101", bus.fbphase, -13086);
      if (bus.tcnt == 700) chk("fb_t700", bus.fbphase, 0);
      if (bus.tcnt >= T1)  chk("fb_hold_v1", bus.fbphase, V1);
      if (bus.tcnt <= 800) begin
        if (phase_sel == 0) fb_hist[bus.tcnt] = bus.fbphase;
        else                chk("replay_after_reset", bus.fbphase, fb_hist[bus.tcnt]);
      end
      prev_rclk  = bus.rclk;
      prev_fbclk = bus.fbclk;
    end
    prev_fb = bus.fbphase;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint s_fb, s_tcnt;
    logic   s_rclk, s_fbclk;
    bus.en = 1'b1;
    rst_n  = 1'b0;

    chk("cyc_to_phase", cyc_to_phase(-0.2), V0);

    repeat (3) tick(1'b0, 1'b1);
    chk("rst_tcnt",   bus.tcnt,    0);
    chk("rst_fb",     bus.fbphase, V0);
    chk("rst_rphase", bus.rphase,  0);
    chk("rst_rclk",   bus.rclk,    0);
    chk("rst_fbclk",  bus.fbclk,   0);

    phase_sel = 0;
    for (int i = 0; i < 2000 && bus.tcnt != 800; i++) tick(1'b1, 1'b1);
    chk("reach_tcnt_800", bus.tcnt, 800);

    tick(1'b0, 1'b1);
    chk("mid_rst_tcnt", bus.tcnt,    0);
    chk("mid_rst_fb",   bus.fbphase, V0);
    chk("mid_rst_rclk", bus.rclk,    0);

    phase_sel = 1;
    while (m_tcnt < 500) tick(1'b1, 1'b1);
    s_fb = bus.fbphase; s_tcnt = bus.tcnt; s_rclk = bus.rclk; s_fbclk = bus.fbclk;
    repeat (50) begin
      tick(1'b1, 1'b0);
      chk("frz_fb",    bus.fbphase, s_fb);
      chk("frz_tcnt",  bus.tcnt,    s_tcnt);
      chk("frz_rclk",  bus.rclk,    s_rclk);
      chk("frz_fbclk", bus.fbclk,   s_fbclk);
    end
    while (m_tcnt < 2000) tick(1'b1, 1'b1);
    chk("end_tcnt", bus.tcnt,    2000);
    chk("end_fb",   bus.fbphase, V1);
    chk("sb_empty", sb.size(),   0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
